// File: rtl/sprite_bank_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// sprite_bank_ram : AHB-Lite written sprite store with a 1-cycle pixel port.
// Optional macro SPRITE_FLIP_EN: header bits 0/1 mirror the pixel fetch.
// Revision 1.0
// ==========================================================================
module sprite_bank_ram #(
   parameter int NUM_SPRITES = 4,
   parameter int DIM_LOG2    = 4,
   localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      HSEL,
   input  logic                      HREADY,
   input  logic [31:0]               HADDR,
   input  logic [1:0]                HTRANS,
   input  logic                      HWRITE,
   input  logic [2:0]                HSIZE,
   input  logic [31:0]               HWDATA,
   output logic                      HREADYOUT,
   output logic [31:0]               HRDATA,
   input  logic                      pix_req,
   input  logic [SEL_W-1:0]          pix_sel,
   input  logic [DIM_LOG2-1:0]       rel_x,
   input  logic [DIM_LOG2-1:0]       rel_y,
   output logic                      pix_valid,
   output logic [31:0]               pix_data,
   output logic [32*NUM_SPRITES-1:0] sprite_hdr
);

   localparam int SLOT_AW   = 2*DIM_LOG2 + 1;
   localparam int MEMWIDTH  = SEL_W + SLOT_AW + 2;
   localparam int PIX_AW    = 2*DIM_LOG2;
   localparam int RAM_AW    = SEL_W + PIX_AW;
   localparam int RAM_DEPTH = NUM_SPRITES << PIX_AW;
   localparam logic [SLOT_AW-1:0] LAST_PIX_OFF = SLOT_AW'((1 << DIM_LOG2) * (1 << DIM_LOG2));

   logic [31:0] pix_ram [RAM_DEPTH];
   logic [31:0] hdr     [NUM_SPRITES];

   logic [SEL_W-1:0]   ap_slot;
   logic [SLOT_AW-1:0] ap_off, ap_off_m1;
   logic [RAM_AW-1:0]  ap_ram_addr;
   logic [3:0]         ap_mask;
   logic               ap_accept, ap_slot_ok, ap_is_hdr, ap_is_pix;

   logic               dp_write, dp_read, dp_is_hdr, dp_is_pix;
   logic [SEL_W-1:0]   dp_slot;
   logic [SLOT_AW-1:0] dp_off;
   logic [RAM_AW-1:0]  dp_ram_addr;
   logic [3:0]         dp_mask;
   logic [31:0]        rd_data, fetch, merged;
   logic               commit, bypass;

   logic               flip_x, flip_y;
   logic [DIM_LOG2-1:0] pix_col, pix_row;
   logic [RAM_AW-1:0]  pix_addr;

   assign ap_accept   = HSEL & HREADY & HTRANS[1];
   assign ap_slot     = HADDR[MEMWIDTH-1 -: SEL_W];
   assign ap_off      = HADDR[SLOT_AW+1:2];
   assign ap_off_m1   = ap_off - SLOT_AW'(1);
   assign ap_ram_addr = {ap_slot, ap_off_m1[PIX_AW-1:0]};
   assign ap_slot_ok  = ({1'b0, ap_slot} < (SEL_W+1)'(NUM_SPRITES));
   assign ap_is_hdr   = ap_slot_ok && (ap_off == '0);
   assign ap_is_pix   = ap_slot_ok && (ap_off != '0) && (ap_off <= LAST_PIX_OFF);

   always_comb begin
      case (HSIZE)
         3'd0:    ap_mask = 4'b0001 << HADDR[1:0];
         3'd1:    ap_mask = HADDR[1] ? 4'b1100 : 4'b0011;
         default: ap_mask = 4'b1111;
      endcase
   end

   assign commit = dp_write & HREADY;
   // A read landing on the word being written this cycle sees the new lanes.
   assign bypass = commit && (dp_slot == ap_slot) && (dp_off == ap_off) && (ap_is_hdr || ap_is_pix);

   always_comb begin
      fetch = '0;
      if (ap_is_hdr)
         fetch = hdr[ap_slot];
      else if (ap_is_pix)
         fetch = pix_ram[ap_ram_addr];
      merged = fetch;
      for (int b = 0; b < 4; b++)
         if (bypass && dp_mask[b])
            merged[8*b +: 8] = HWDATA[8*b +: 8];
   end

`ifdef SPRITE_FLIP_EN
   assign flip_x = hdr[pix_sel][0];
   assign flip_y = hdr[pix_sel][1];
`else
   assign flip_x = 1'b0;
   assign flip_y = 1'b0;
`endif
   assign pix_col  = flip_x ? ~rel_x : rel_x;
   assign pix_row  = flip_y ? ~rel_y : rel_y;
   assign pix_addr = {pix_sel, pix_row, pix_col};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dp_write    <= 1'b0;
         dp_read     <= 1'b0;
         dp_is_hdr   <= 1'b0;
         dp_is_pix   <= 1'b0;
         dp_slot     <= '0;
         dp_off      <= '0;
         dp_ram_addr <= '0;
         dp_mask     <= '0;
         rd_data     <= '0;
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         for (int s = 0; s < NUM_SPRITES; s++)
            hdr[s] <= '0;
      end else begin
         if (HREADY) begin
            dp_write    <= ap_accept & HWRITE;
            dp_read     <= ap_accept & ~HWRITE;
            dp_is_hdr   <= ap_is_hdr;
            dp_is_pix   <= ap_is_pix;
            dp_slot     <= ap_slot;
            dp_off      <= ap_off;
            dp_ram_addr <= ap_ram_addr;
            dp_mask     <= ap_mask;
            if (ap_accept && !HWRITE)
               rd_data <= merged;
         end
         for (int b = 0; b < 4; b++)
            if (commit && dp_is_hdr && dp_mask[b])
               hdr[dp_slot][8*b +: 8] <= HWDATA[8*b +: 8];
         pix_valid <= pix_req;
         pix_data  <= pix_req ? pix_ram[pix_addr] : '0;
      end
   end

   // Pixel storage is not reset; a write aborted by reset never reaches here.
   always_ff @(posedge HCLK) begin
      for (int b = 0; b < 4; b++)
         if (commit && dp_is_pix && dp_mask[b])
            pix_ram[dp_ram_addr][8*b +: 8] <= HWDATA[8*b +: 8];
   end

   assign HREADYOUT = 1'b1;
   assign HRDATA    = dp_read ? rd_data : '0;

   for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_hdr
      assign sprite_hdr[32*s +: 32] = hdr[s];
   end

   logic unused_bits;
   assign unused_bits = &{1'b0, HADDR[31:MEMWIDTH], HTRANS[0], ap_off_m1[SLOT_AW-1:PIX_AW]};

endmodule
`default_nettype wire

// File: tb/tb_sprite_bank_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_sprite_bank_ram : random + directed scoreboard bench for sprite_bank_ram
// Revision 1.0
// ==========================================================================
module tb_sprite_bank_ram;

   localparam int NUM_SPRITES = 4;
   localparam int DIM_LOG2    = 4;
   localparam int SEL_W       = 2;
   localparam int DIM         = 16;
   localparam int SLOT_WORDS  = 512;
   localparam int PIX_WORDS   = 256;
   localparam int MEMWIDTH    = 13;
   localparam int NWORDS      = 2048;
   localparam int K_IDLE = 0, K_NOSEL = 1, K_WR = 2, K_RD = 3;

   logic        HCLK, HRESET, HSEL, HREADY, HWRITE, HREADYOUT;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        pix_req, pix_valid;
   logic [SEL_W-1:0]    pix_sel;
   logic [DIM_LOG2-1:0] rel_x, rel_y;
   logic [31:0] pix_data;
   logic [32*NUM_SPRITES-1:0] sprite_hdr;

   sprite_bank_ram #(.NUM_SPRITES(NUM_SPRITES), .DIM_LOG2(DIM_LOG2)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .pix_req(pix_req), .pix_sel(pix_sel),
      .rel_x(rel_x), .rel_y(rel_y), .pix_valid(pix_valid), .pix_data(pix_data),
      .sprite_hdr(sprite_hdr)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] data;
      bit          pix;
      int          sel, x, y;
   } txn_t;

   // m_issue: memory as seen by bus reads (writes apply in issue order);
   // m_comm : memory as seen by the pixel port (writes land one cycle later).
   logic [31:0] m_issue [NWORDS];
   logic [31:0] m_comm  [NWORDS];
   logic [31:0] q_rd[$], q_pix[$];
   bit          pend_v;
   logic [31:0] pend_a, pend_d, last_addr;
   logic [2:0]  pend_sz;
   bit          mon_on, mon_rd_acc;
   int          n_vec, n_err;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ad(input int s, input int off, input int lo);
      return 32'((s*SLOT_WORDS + off)*4 + lo);
   endfunction

   function automatic logic [3:0] lane_mask(input logic [31:0] a, input logic [2:0] sz);
      if (sz == 3'd0) return 4'b0001 << a[1:0];
      if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic void mwrite(input bit comm, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      int wa, off;
      logic [3:0] m;
      wa  = int'(a[MEMWIDTH-1:2]);
      off = wa % SLOT_WORDS;
      if (off > PIX_WORDS) return;
      m = lane_mask(a, sz);
      for (int b = 0; b < 4; b++)
         if (m[b]) begin
            if (comm) m_comm[wa][8*b +: 8] = d[8*b +: 8];
            else      m_issue[wa][8*b +: 8] = d[8*b +: 8];
         end
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a);
      int wa;
      wa = int'(a[MEMWIDTH-1:2]);
      if ((wa % SLOT_WORDS) > PIX_WORDS) return 32'h0;
      return m_issue[wa];
   endfunction

   function automatic logic [31:0] pix_ref(input int sel, input int x, input int y);
      int row, col;
      row = y;
      col = x;
`ifdef SPRITE_FLIP_EN
      if (m_comm[sel*SLOT_WORDS][0]) col = DIM-1-x;
      if (m_comm[sel*SLOT_WORDS][1]) row = DIM-1-y;
`endif
      return m_comm[sel*SLOT_WORDS + 1 + row*DIM + col];
   endfunction

   function automatic txn_t mk(input int kind, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      txn_t t;
      t.kind = kind; t.addr = a; t.size = sz; t.data = d;
      t.pix = 1'b0; t.sel = 0; t.x = 0; t.y = 0;
      return t;
   endfunction

   function automatic txn_t with_pix(input txn_t t, input int sel, input int x, input int y);
      txn_t r;
      r = t; r.pix = 1'b1; r.sel = sel; r.x = x; r.y = y;
      return r;
   endfunction

   task automatic step(input txn_t t);
      @(negedge HCLK);
      if (t.pix) q_pix.push_back(pix_ref(t.sel, t.x, t.y));
      if (pend_v) mwrite(1'b1, pend_a, pend_sz, pend_d);
      HWDATA = pend_v ? pend_d : $urandom();
      pend_v = 1'b0;
      HSEL = 1'b1; HREADY = 1'b1; HADDR = t.addr; HSIZE = t.size;
      HWRITE = 1'($urandom_range(0, 1));
      case (t.kind)
         K_IDLE:  HTRANS = {1'b0, 1'($urandom_range(0, 1))};
         K_NOSEL: begin HSEL = 1'b0; HTRANS = 2'b10; end
         K_WR: begin
            HTRANS = {1'b1, 1'($urandom_range(0, 1))};
            HWRITE = 1'b1;
            mwrite(1'b0, t.addr, t.size, t.data);
            pend_v = 1'b1; pend_a = t.addr; pend_sz = t.size; pend_d = t.data;
         end
         default: begin
            HTRANS = {1'b1, 1'($urandom_range(0, 1))};
            HWRITE = 1'b0;
            q_rd.push_back(mread(t.addr));
         end
      endcase
      pix_req = t.pix;
      pix_sel = SEL_W'(t.sel);
      rel_x   = DIM_LOG2'(t.x);
      rel_y   = DIM_LOG2'(t.y);
   endtask

   // Monitor: checks outputs one time unit after each rising edge.
   initial begin
      logic [127:0] eh;
      forever begin
         @(posedge HCLK);
         mon_rd_acc = HSEL && HREADY && HTRANS[1] && !HWRITE;
         #1;
         if (mon_on) begin
            if (mon_rd_acc) begin
               if (q_rd.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL hrdata_unexpected: got %0h expected none", HRDATA);
               end else chk("hrdata", HRDATA, q_rd.pop_front());
            end else chk("hrdata_idle", HRDATA, 0);
            if (pix_valid) begin
               if (q_pix.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL pix_unexpected: got %0h expected none", pix_data);
               end else chk("pix_data", pix_data, q_pix.pop_front());
            end else chk("pix_data_idle", pix_data, 0);
            for (int s = 0; s < NUM_SPRITES; s++) eh[32*s +: 32] = m_comm[s*SLOT_WORDS];
            chk("sprite_hdr", sprite_hdr, eh);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      txn_t t;
      logic [31:0] a;
      int k;
      for (int i = 0; i < NWORDS; i++) begin m_issue[i] = '0; m_comm[i] = '0; end
      n_vec = 0; n_err = 0; mon_on = 1'b0; pend_v = 1'b0; last_addr = '0;
      HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0; HTRANS = 2'b00;
      HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = '0; pix_req = 1'b0; pix_sel = '0;
      rel_x = '0; rel_y = '0;

      // Reset behaviour around a header write in flight.
      repeat (3) @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0; HSIZE = 3'd2;
      @(negedge HCLK);
      HWDATA = 32'h1111_1111; HWRITE = 1'b0; pix_req = 1'b1;
      @(negedge HCLK);
      chk("rst_pre_hdr0", sprite_hdr[31:0], 32'h1111_1111);
      chk("rst_pre_bypass", HRDATA, 32'h1111_1111);
      chk("rst_pre_pixv", pix_valid, 1);
      HWDATA = $urandom(); HWRITE = 1'b1;
      @(negedge HCLK);
      HWDATA = 32'hCAFE_F00D; HTRANS = 2'b00; pix_req = 1'b0;
      #2 HRESET = 1'b1;
      #1;
      chk("rst_hdr", sprite_hdr, 0);
      chk("rst_hrdata", HRDATA, 0);
      chk("rst_pixv", pix_valid, 0);
      chk("rst_pixd", pix_data, 0);
      @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);
      chk("rst_write_dropped", sprite_hdr, 0);
      mon_on = 1'b1;

      // Fill every slot so the pixel RAM is fully defined.
      for (int s = 0; s < NUM_SPRITES; s++)
         for (int off = 0; off <= PIX_WORDS; off++)
            step(mk(K_WR, ad(s, off, 0), 3'd2, $urandom()));
      for (int s = 0; s < NUM_SPRITES; s++) step(mk(K_WR, ad(s, 0, 0), 3'd2, 32'h0));

      // Word write, readback, pixel fetch.
      step(mk(K_WR, ad(1, 5, 0), 3'd2, 32'hDEAD_BEEF));
      step(mk(K_RD, ad(1, 5, 0), 3'd2, 0));
      step(with_pix(mk(K_IDLE, 0, 3'd2, 0), 1, 4, 0));

      // Byte and half-word lanes, each read directly behind its write.
      step(mk(K_WR, ad(2, 17, 0), 3'd2, 32'h1122_3344));
      step(mk(K_WR, ad(2, 17, 2), 3'd0, 32'h55AA_66BB));
      step(mk(K_RD, ad(2, 17, 0), 3'd2, 0));
      step(mk(K_WR, ad(2, 17, 2), 3'd1, 32'hBEEF_1234));
      step(mk(K_RD, ad(2, 17, 0), 3'd2, 0));

      // Bypass and holes.
      step(mk(K_WR, ad(3, 200, 0), 3'd2, 32'h1234_5678));
      step(mk(K_RD, ad(3, 200, 0), 3'd2, 0));
      step(mk(K_RD, ad(0, 300, 0), 3'd2, 0));
      step(mk(K_WR, ad(0, 300, 0), 3'd2, 32'hDEAD_DEAD));
      step(mk(K_RD, ad(0, 300, 0), 3'd2, 0));

      // Pixel read in the same cycle as the AHB commit returns old data.
      step(mk(K_WR, ad(0, 1 + 3*DIM + 7, 0), 3'd2, 32'h9));
      step(mk(K_IDLE, 0, 3'd2, 0));
      step(mk(K_WR, ad(0, 1 + 3*DIM + 7, 0), 3'd2, 32'h5));
      step(with_pix(mk(K_IDLE, 0, 3'd2, 0), 0, 7, 3));
      step(with_pix(mk(K_IDLE, 0, 3'd2, 0), 0, 7, 3));

      // Header flip bits.
      step(mk(K_WR, ad(2, 1, 0), 3'd2, 32'h0000_A0A0));
      step(mk(K_WR, ad(2, PIX_WORDS, 0), 3'd2, 32'h0000_F0F0));
      step(mk(K_WR, ad(2, 0, 0), 3'd2, 32'h3));
      step(mk(K_IDLE, 0, 3'd2, 0));
      step(with_pix(mk(K_IDLE, 0, 3'd2, 0), 2, 0, 0));
      step(with_pix(mk(K_IDLE, 0, 3'd2, 0), 2, DIM-1, DIM-1));

      // Randomised traffic with frequent same-word reuse.
      for (int i = 0; i < 3000; i++) begin
         k = $urandom_range(0, 9);
         if ($urandom_range(0, 2) == 0)
            a = {last_addr[31:2], 2'($urandom_range(0, 3))};
         else begin
            a = $urandom();
            a = (a << MEMWIDTH) | ad($urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(257, 511) : $urandom_range(0, 256),
                $urandom_range(0, 3));
         end
         last_addr = a;
         t = mk((k < 2) ? K_IDLE : (k == 2) ? K_NOSEL : (k < 7) ? K_WR : K_RD,
                a, 3'($urandom_range(0, 7)), $urandom());
         if ($urandom_range(0, 1) == 1)
            t = with_pix(t, $urandom_range(0, 3), $urandom_range(0, DIM-1), $urandom_range(0, DIM-1));
         step(t);
      end

      repeat (3) step(mk(K_IDLE, 0, 3'd2, 0));
      @(negedge HCLK);
      @(negedge HCLK);
      mon_on = 1'b0;
      chk("rd_queue_drained", q_rd.size(), 0);
      chk("pix_queue_drained", q_pix.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
